// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the central pipeline controller.
// master = stage side (raises requests), slave = controller side.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             stallreq_if_i;
   logic             stallreq_id_i;
   logic             stallreq_ex_i;
   logic             stallreq_mem_i;
   logic             flush_req_i;
   logic [31:0]      flush_pc_i;
   logic [5:0]       stall_o;
   logic             flush_o;
   logic [31:0]      new_pc_o;
   logic             timeout_o;
   logic [CNT_W-1:0] perf_stall_cnt_o;
   logic [1:0]       dbg_state_o;

   modport master (
      output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      output flush_req_i, flush_pc_i,
      input  stall_o, flush_o, new_pc_o, timeout_o, perf_stall_cnt_o, dbg_state_o
   );

   modport slave (
      input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      input  flush_req_i, flush_pc_i,
      output stall_o, flush_o, new_pc_o, timeout_o, perf_stall_cnt_o, dbg_state_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into a hold vector, sequences
// exception/redirect flushes, and tracks stall run-length (watchdog) and total stall cycles.
module pipe_ctrl #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic         clk,
   input  logic         rst,
   pipe_ctrl_if.slave   bus
);
   localparam int RW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_FLUSH_WAIT = 2'd1,
      ST_FLUSH      = 2'd2
   } state_t;

   state_t           r_state;
   logic [31:0]      r_pc;
   logic [31:0]      r_new_pc;
   logic             r_flush;
   logic             r_timeout;
   logic [RW-1:0]    r_run;
   logic [CNT_W-1:0] r_perf;

   logic [5:0]       w_tab;
   logic [5:0]       w_stall;
   logic             w_stalled;
   logic             w_hit;

   // Highest requesting stage wins; it and everything upstream hold, WB never does.
   always_comb begin
      w_tab = 6'b000000;
      if (bus.stallreq_mem_i)      w_tab = 6'b011111;
      else if (bus.stallreq_ex_i)  w_tab = 6'b001111;
      else if (bus.stallreq_id_i)  w_tab = 6'b000111;
      else if (bus.stallreq_if_i)  w_tab = 6'b000011;
   end

   assign w_stall   = (rst || r_flush) ? 6'b000000 : w_tab;
   assign w_stalled = |w_stall;
   // Flag rises during the stalled cycle that brings the run length to TIMEOUT.
   assign w_hit     = w_stalled && (r_run >= RW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_RUN;
         r_pc      <= 32'd0;
         r_new_pc  <= 32'd0;
         r_flush   <= 1'b0;
         r_timeout <= 1'b0;
         r_run     <= '0;
         r_perf    <= '0;
      end else begin
         r_perf  <= r_perf + CNT_W'(w_stalled);
         r_flush <= 1'b0;
         if (!w_stalled)                  r_run <= '0;
         else if (r_run != RW'(TIMEOUT))  r_run <= r_run + RW'(1);
         if (w_hit) r_timeout <= 1'b1;

         case (r_state)
            ST_RUN: begin
               if (bus.flush_req_i) begin
                  r_pc <= bus.flush_pc_i;
                  if (bus.stallreq_mem_i) begin
                     r_state <= ST_FLUSH_WAIT;
                  end else begin
                     r_state  <= ST_FLUSH;
                     r_flush  <= 1'b1;
                     r_new_pc <= bus.flush_pc_i;
                  end
               end
            end
            ST_FLUSH_WAIT: begin
               // Later flush requests are dropped; the first redirect target is kept.
               if (!bus.stallreq_mem_i) begin
                  r_state  <= ST_FLUSH;
                  r_flush  <= 1'b1;
                  r_new_pc <= r_pc;
               end
            end
            ST_FLUSH: r_state <= ST_RUN;
            default:  r_state <= ST_RUN;
         endcase
      end
   end

   assign bus.stall_o          = w_stall;
   assign bus.flush_o          = r_flush;
   assign bus.new_pc_o         = r_new_pc;
   assign bus.timeout_o        = r_timeout | w_hit;
   assign bus.perf_stall_cnt_o = r_perf;
   assign bus.dbg_state_o      = r_state;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, checked cycle by cycle
// against a behavioural model through an expected-value queue.
module tb_pipe_ctrl;
   localparam int TO = 8;
   localparam int EW = 72;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.CNT_W(32)) bus ();

   pipe_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // {stall[6], flush, new_pc[32], timeout, perf[32]}
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   bit          m_flush_next;
   bit          m_pending;
   logic [31:0] m_pc;
   logic [31:0] m_newpc;
   logic [31:0] m_perf;
   int          m_run;
   bit          m_timeout;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Number of held stages grows with the deepest requesting stage.
   function automatic logic [5:0] ref_stall(input bit fi, id, ex, mem);
      int n;
      n = mem ? 5 : ex ? 4 : id ? 3 : fi ? 2 : 0;
      return 6'((1 << n) - 1);
   endfunction

   task automatic model_reset();
      m_flush_next = 0; m_pending = 0;
      m_pc = 0; m_newpc = 0; m_perf = 0; m_run = 0; m_timeout = 0;
   endtask

   task automatic step(input bit r, input bit fi, input bit id, input bit ex, input bit mem,
                       input bit fr, input logic [31:0] fpc);
      logic [5:0] e_stall;
      bit         e_to;
      bit         e_flush;
      @(posedge clk); #1;
      rst = r;
      bus.stallreq_if_i  = fi;
      bus.stallreq_id_i  = id;
      bus.stallreq_ex_i  = ex;
      bus.stallreq_mem_i = mem;
      bus.flush_req_i    = fr;
      bus.flush_pc_i     = fpc;
      if (r) begin
         model_reset();
      end else begin
         e_flush = m_flush_next;
         e_stall = e_flush ? 6'd0 : ref_stall(fi, id, ex, mem);
         e_to    = m_timeout || ((e_stall != 0) && (m_run + 1 >= TO));
         exp_q.push_back({e_stall, e_flush, m_newpc, e_to, m_perf});
         if (e_stall != 0) begin
            m_perf = m_perf + 1;
            m_run  = (m_run + 1 > TO) ? TO : m_run + 1;
         end else begin
            m_run = 0;
         end
         m_timeout = e_to;
         if (e_flush) begin
            m_flush_next = 0;
         end else if (m_pending) begin
            if (!mem) begin
               m_flush_next = 1; m_newpc = m_pc; m_pending = 0;
            end
         end else if (fr) begin
            m_pc = fpc;
            if (mem) m_pending = 1;
            else begin
               m_flush_next = 1; m_newpc = fpc;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'd0);
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("stall",   {26'd0, bus.stall_o},   {26'd0, e[71:66]});
         chk("flush",   {31'd0, bus.flush_o},   {31'd0, e[65]});
         chk("new_pc",  bus.new_pc_o,           e[64:33]);
         chk("timeout", {31'd0, bus.timeout_o}, {31'd0, e[32]});
         chk("perf",    bus.perf_stall_cnt_o,   e[31:0]);
      end
   end

   initial begin
      rst = 1'b1;
      bus.stallreq_if_i = 0; bus.stallreq_id_i = 0; bus.stallreq_ex_i = 0;
      bus.stallreq_mem_i = 0; bus.flush_req_i = 0; bus.flush_pc_i = 32'd0;
      model_reset();
      step(1, 0, 0, 0, 0, 0, 32'd0);
      step(1, 0, 0, 0, 0, 0, 32'd0);
      idle(2);

      // load-use stall for three cycles
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 32'd0);
      idle(2);

      // several stages at once, then drop mem
      step(0, 1, 0, 1, 1, 0, 32'd0);
      step(0, 1, 0, 1, 0, 0, 32'd0);
      idle(2);

      // unstalled redirect
      step(0, 0, 0, 0, 0, 1, 32'h0000_0180);
      idle(3);

      // redirect while MEM waits; second request must be ignored
      step(0, 0, 0, 0, 1, 0, 32'd0);
      step(0, 0, 0, 0, 1, 1, 32'h0000_0200);
      step(0, 0, 0, 0, 1, 0, 32'd0);
      step(0, 0, 0, 0, 1, 1, 32'h0000_0300);
      step(0, 0, 0, 0, 1, 0, 32'd0);
      idle(3);

      // watchdog: 7-cycle burst, gap, 8-cycle burst, then reset clears it
      step(1, 0, 0, 0, 0, 0, 32'd0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0, 32'd0);
      idle(1);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0, 32'd0);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 32'd0);
      idle(2);

      // reset while a flush is pending behind a MEM stall
      step(0, 0, 0, 0, 1, 0, 32'd0);
      step(0, 0, 0, 0, 1, 1, 32'h0000_0400);
      step(0, 0, 0, 0, 1, 0, 32'd0);
      step(1, 0, 0, 0, 1, 0, 32'd0);
      idle(4);

      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0,
              $urandom());
      end
      idle(2);

      @(negedge clk); #1;
      chk("drain", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
